// File: rtl/multicycle_controller_if.sv
// Instruction and data memory request handshakes
// between the multicycle sequencer and the memories.
interface multicycle_controller_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    input  imem_ready,
    output dmem_req,
    output dmem_we,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    output imem_ready,
    input  dmem_req,
    input  dmem_we,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: fetch, decode, execute,
// memory, writeback, with retire count and bus timeout.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  multicycle_controller_if.master bus,
  output logic                    ir_load,
  input  logic                    dec_reg_write_en,
  input  logic                    dec_mem_read_en,
  input  logic                    dec_mem_write_en,
  input  logic                    dec_is_branch,
  input  logic                    dec_is_jal,
  input  logic                    dec_is_jalr,
  input  logic                    dec_illegal,
  input  logic                    cmp_result,
  output logic                    exec_latch,
  output logic                    rf_write,
  output logic                    wb_src,
  output logic                    pc_write,
  output logic [1:0]              pc_src,
  output logic                    retire,
  output logic [CNT_WIDTH-1:0]    instret,
  output logic                    halted,
  output logic                    bus_error,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam int WW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] W_LIMIT = WW'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t               r_state;
  state_t               w_next;
  logic [WW-1:0]        r_wait;
  logic [WW-1:0]        w_wait_inc;
  logic                 r_rw;
  logic                 r_mr;
  logic                 r_mw;
  logic                 r_br;
  logic                 r_jal;
  logic                 r_jalr;
  logic [CNT_WIDTH-1:0] r_instret;
  logic                 r_bus_error;
  logic                 w_stall;
  logic                 w_timeout;

  // A cycle spent with a request up and no ready back
  assign w_stall =
    (r_state == S_FETCH && run && !bus.imem_ready) ||
    (r_state == S_MEM && !bus.dmem_ready);
  assign w_wait_inc = r_wait + WW'(1);
  assign w_timeout =
    TO_EN && w_stall && (w_wait_inc == W_LIMIT);

  assign instret   = rst ? '0 : r_instret;
  assign bus_error = rst ? 1'b0 : r_bus_error;
  assign state_dbg = rst ? 3'd0 : r_state;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next-state logic; unused encodings fall into HALT
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (run && bus.imem_ready) w_next = S_DECODE;
        else if (w_timeout)        w_next = S_HALT;
      end
      S_DECODE:
        w_next = dec_illegal ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        if (r_mr || r_mw) w_next = S_MEM;
        else if (r_br)    w_next = S_FETCH;
        else              w_next = S_WB;
      end
      S_MEM: begin
        if (bus.dmem_ready) w_next = r_mr ? S_WB : S_FETCH;
        else if (w_timeout) w_next = S_HALT;
      end
      S_WB:    w_next = S_FETCH;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end

  // Control outputs, forced low while reset is held
  always_comb begin
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    ir_load      = 1'b0;
    exec_latch   = 1'b0;
    rf_write     = 1'b0;
    wb_src       = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    retire       = 1'b0;
    halted       = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          bus.imem_req = run;
          ir_load      = run & bus.imem_ready;
        end
        S_DECODE: begin
        end
        S_EXECUTE: begin
          exec_latch = 1'b1;
          if (!(r_mr || r_mw) && r_br) begin
            pc_write = 1'b1;
            pc_src   = cmp_result ? 2'b01 : 2'b00;
            retire   = 1'b1;
          end
        end
        S_MEM: begin
          bus.dmem_req = 1'b1;
          bus.dmem_we  = r_mw;
          if (bus.dmem_ready && !r_mr) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end
        end
        S_WB: begin
          rf_write = r_rw;
          wb_src   = r_mr;
          pc_write = 1'b1;
          retire   = 1'b1;
          unique case (1'b1)
            r_jal:   pc_src = 2'b01;
            r_jalr:  pc_src = 2'b10;
            default: pc_src = 2'b00;
          endcase
        end
        default: halted = 1'b1;
      endcase
    end
  end

  // Capture decoder flags once; a load wins over a store
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rw   <= 1'b0;
      r_mr   <= 1'b0;
      r_mw   <= 1'b0;
      r_br   <= 1'b0;
      r_jal  <= 1'b0;
      r_jalr <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_rw   <= dec_reg_write_en;
      r_mr   <= dec_mem_read_en;
      r_mw   <= dec_mem_write_en & ~dec_mem_read_en;
      r_br   <= dec_is_branch;
      r_jal  <= dec_is_jal;
      r_jalr <= dec_is_jalr;
    end
  end

  // Memory wait counter, cleared whenever the state changes
  always_ff @(posedge clk) begin
    if (rst)                    r_wait <= '0;
    else if (w_next != r_state) r_wait <= '0;
    else if (w_stall)           r_wait <= w_wait_inc;
  end

  // Sticky bus error and wrapping retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_error <= 1'b0;
      r_instret   <= '0;
    end else begin
      if (w_timeout) r_bus_error <= 1'b1;
      if (retire)    r_instret   <= r_instret + 1'b1;
    end
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the RV32I core. Steps each instruction through fetch, decode, execute, memory and writeback.
- Consumes the instruction decoder's control outputs and the comparator result.
- Drives the IR/PC/register-file enables and the instruction and data memory request handshakes.
- Provides a retired-instruction counter, memory wait timeout and halt-on-error.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles a memory request waits for ready before bus error; 0 disables the timeout.
- CNT_WIDTH, 32, width of instret counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- run  in  1  permits a new fetch; sampled in FETCH only.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid.
- ir_load  out  1  load instruction register (1-cycle pulse).
- dec_reg_write_en  in  1  decoder reg_write_en.
- dec_mem_read_en  in  1  decoder mem_read_en.
- dec_mem_write_en  in  1  decoder mem_write_en.
- dec_is_branch  in  1  B-type.
- dec_is_jal  in  1  JAL.
- dec_is_jalr  in  1  JALR.
- dec_illegal  in  1  unrecognised opcode.
- cmp_result  in  1  comparator output.
- exec_latch  out  1  capture ALU/shifter/comparator result.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  write strobe, valid with dmem_req.
- dmem_ready  in  1  data access complete.
- rf_write  out  1  register file write enable.
- wb_src  out  1  0: execute result, 1: memory data.
- pc_write  out  1  update PC.
- pc_src  out  2  00 pc+4, 01 pc+imm, 10 rs1+imm.
- retire  out  1  instruction completed (pulse).
- instret  out  CNT_WIDTH  retired-instruction count.
- halted  out  1  core stopped.
- bus_error  out  1  halt cause was a timeout.
- state_dbg  out  3  current state.

Behaviour:
- States (encoding): FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5; others go to HALT.
- Reset: state FETCH, instret 0, halted 0, bus_error 0, wait counter 0, latched flags 0.
- While rst=1 all outputs are 0; an outstanding request is abandoned, with no retire.
- Default for every control output is 0 unless stated for the current state.
- FETCH:
  - imem_req = run.
  - On imem_req & imem_ready: ir_load = 1, go to DECODE.
- DECODE (1 cycle): latch all dec_* inputs into internal flags. Later states use only the latched flags.
  - dec_illegal -> HALT.
  - Otherwise -> EXECUTE.
- EXECUTE (1 cycle): exec_latch = 1, then:
  - mem_read or mem_write -> MEM.
  - Branch: pc_write = 1, pc_src = cmp_result ? 01 : 00, retire, -> FETCH.
  - Else -> WRITEBACK.
- MEM: dmem_req = 1, dmem_we = latched mem_write. On dmem_ready:
  - Store: pc_write = 1, pc_src = 00, retire, -> FETCH.
  - Load: -> WRITEBACK.
- WRITEBACK (1 cycle):
  - rf_write = latched reg_write; wb_src = latched mem_read.
  - pc_write = 1, pc_src = jal ? 01 : jalr ? 10 : 00.
  - retire, -> FETCH.
- Request handshake:
  - req stays high and stable until ready is seen in the same cycle.
  - ready while req=0 is ignored.
  - A store and a load are never both latched; if both are, treat it as a load.
- Timeout:
  - Wait counter increments each cycle in FETCH (with req=1) or MEM without ready; it clears on state exit.
  - When it reaches TIMEOUT_CYCLES (nonzero) without ready: -> HALT, bus_error = 1, request dropped.
  - Ready arriving in the same cycle as the limit wins: no error.
- HALT: halted = 1, all requests 0, exit only via rst.
- instret:
  - Increments on each retire and wraps modulo 2^CNT_WIDTH.
  - The new value is visible the cycle after retire.
- Latency with zero-wait memory:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.

Test Plan:
- ADD stream, run=1, imem_ready always 1 -> retire every 4 cycles; rf_write=1, wb_src=0 in WRITEBACK; instret=3 after 12 cycles.
- LW with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0; WRITEBACK gives rf_write=1, wb_src=1; 8 cycles total.
- BEQ with cmp_result=1, then BNE with cmp_result=0 -> pc_src 01 then 00 in EXECUTE; rf_write never asserted; 3 cycles each.
- TIMEOUT_CYCLES=4 with dmem_ready held 0 on SW -> HALT after 4 wait cycles; halted=1, bus_error=1, dmem_req=0, instret unchanged.
- rst pulsed mid-MEM, then dec_illegal=1 on the next fetch -> after rst: state_dbg=0, imem_req=1, instret=0; illegal gives HALT with bus_error=0.
- CNT_WIDTH=4, 17 retires -> instret wraps to 1.
